siganfu_turret_controller: RTL and testbench

- Parametrised, fully synchronous successor to the single/auto machine-gun FSM.
- Adds a burst mode and cycle-counted shot, reload and cooldown timing, with no behavioural delays.
- Adds explicit ammo-count outputs and a rearm input for recovery from downfall.
- Sits between the targeting front-end (lock, IFF, operator command) and the trigger solenoid driver.

---
 rtl/siganfu_pkg.sv | 31 +++
 rtl/siganfu_turret_controller_if.sv | 27 ++
 rtl/siganfu_shot_timer.sv | 78 +++++++
 rtl/siganfu_turret_controller.sv | 178 +++++++++++++++++
 tb/tb_siganfu_turret_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/siganfu_pkg.sv
// Shared types and elaboration helpers for the Siganfu turret controller.
// State and firing-mode encodings are visible on ports, so values are fixed.
package siganfu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_SINGLE   = 3'b001,
    ST_AUTO     = 3'b010,
    ST_RELOAD   = 3'b011,
    ST_OVERHEAT = 3'b100,
    ST_DOWNFALL = 3'b101,
    ST_BURST    = 3'b110
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'b00,
    MODE_BURST      = 2'b01,
    MODE_AUTO       = 2'b10,
    MODE_ALT_SINGLE = 2'b11
  } mode_t;

  // Bits needed for a down-counter loaded with max_count-1.
  function automatic int timer_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/siganfu_turret_controller_if.sv
// Front-end / solenoid-side signal bundle of the turret controller.
// master = targeting front-end, slave = controller.
interface siganfu_turret_controller_if #(
  parameter int AMMO_W = 8
);
  logic              target_locked;
  logic              is_enemy;
  logic              fire_command;
  logic [1:0]        firing_mode;
  logic              overheat_sensor;
  logic              rearm;
  logic [2:0]        current_state;
  logic              fire_trigger;
  logic              criticality_alert;
  logic [AMMO_W-1:0] bullets_left;
  logic [AMMO_W-1:0] mags_left;

  modport master (
    output target_locked, is_enemy, fire_command, firing_mode, overheat_sensor, rearm,
    input  current_state, fire_trigger, criticality_alert, bullets_left, mags_left
  );

  modport slave (
    input  target_locked, is_enemy, fire_command, firing_mode, overheat_sensor, rearm,
    output current_state, fire_trigger, criticality_alert, bullets_left, mags_left
  );
endinterface

// File: rtl/siganfu_shot_timer.sv
// One shot = FIRE_PULSE cycles of trigger high followed by FIRE_GAP cycles low.
// shot_done flags the last gap cycle so the next shot can start on the same edge.
module siganfu_shot_timer
  import siganfu_pkg::*;
#(
  parameter int FIRE_PULSE = 5,
  parameter int FIRE_GAP   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic trigger,
  output logic shot_done,
  output logic busy
);

  localparam int CW = timer_width(max2(FIRE_PULSE, FIRE_GAP));
  localparam logic [CW-1:0] PULSE_LOAD = CW'(FIRE_PULSE - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(FIRE_GAP - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {PH_IDLE, PH_PULSE, PH_GAP} phase_t;

  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          trigger_n;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    phase_n   = phase;
    cnt_n     = cnt;
    trigger_n = trigger;
    if (abort) begin
      phase_n   = PH_IDLE;
      cnt_n     = '0;
      trigger_n = 1'b0;
    end else if (start) begin
      phase_n   = PH_PULSE;
      cnt_n     = PULSE_LOAD;
      trigger_n = 1'b1;
    end else begin
      case (phase)
        PH_PULSE: begin
          if (cnt == '0) begin
            phase_n   = PH_GAP;
            cnt_n     = GAP_LOAD;
            trigger_n = 1'b0;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        PH_GAP: begin
          if (cnt == '0) phase_n = PH_IDLE;
          else           cnt_n   = cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign shot_done = (phase == PH_GAP) && (cnt == '0);
  assign busy      = (phase != PH_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!rst_n) begin
      phase   <= PH_IDLE;
      cnt     <= '0;
      trigger <= 1'b0;
    end else begin
      phase   <= phase_n;
      cnt     <= cnt_n;
      trigger <= trigger_n;
    end
  end

endmodule

// File: rtl/siganfu_turret_controller.sv
// Turret fire-control FSM: single/burst/auto firing, magazine accounting,
// reload and overheat timing (one shared down-counter), downfall recovery.
module siganfu_turret_controller
  import siganfu_pkg::*;
#(
  parameter int MAG_SIZE      = 25,
  parameter int MAG_COUNT     = 3,
  parameter int BURST_LEN     = 3,
  parameter int FIRE_PULSE    = 5,
  parameter int FIRE_GAP      = 5,
  parameter int RELOAD_CYCLES = 50,
  parameter int COOL_CYCLES   = 100,
  parameter int AMMO_W        = 8
) (
  input logic                   sysclk,
  input logic                   reboot_n,
  siganfu_turret_controller_if.slave bus
);

  localparam int TW = timer_width(max2(RELOAD_CYCLES, COOL_CYCLES));
  localparam int BW = timer_width(BURST_LEN);

  localparam logic [TW-1:0]     RELOAD_LOAD  = TW'(RELOAD_CYCLES - 1);
  localparam logic [TW-1:0]     COOL_LOAD    = TW'(COOL_CYCLES - 1);
  localparam logic [TW-1:0]     TIMER_ONE    = TW'(1);
  localparam logic [BW-1:0]     BURST_LOAD   = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0]     BURST_ONE    = BW'(1);
  localparam logic [AMMO_W-1:0] FULL_MAG     = AMMO_W'(MAG_SIZE);
  localparam logic [AMMO_W-1:0] FULL_SPARES  = AMMO_W'(MAG_COUNT);
  localparam logic [AMMO_W-1:0] AMMO_ONE     = AMMO_W'(1);

  state_t            state, state_n, empty_state;
  logic [AMMO_W-1:0] bullets, bullets_n;
  logic [AMMO_W-1:0] mags, mags_n;
  logic [TW-1:0]     timer, timer_n;
  logic [BW-1:0]     burst, burst_n;
  logic              alert;
  logic              cond;
  logic              shot_start, shot_abort, shot_done, shot_busy, trigger;

  assign cond        = bus.is_enemy & bus.target_locked & bus.fire_command;
  assign empty_state = (mags != '0) ? ST_RELOAD : ST_DOWNFALL;

  siganfu_shot_timer #(
    .FIRE_PULSE (FIRE_PULSE),
    .FIRE_GAP   (FIRE_GAP)
  ) u_shot (
    .clk       (sysclk),
    .rst_n     (reboot_n),
    .start     (shot_start),
    .abort     (shot_abort),
    .trigger   (trigger),
    .shot_done (shot_done),
    .busy      (shot_busy)
  );

  always_comb begin
    state_n    = state;
    bullets_n  = bullets;
    mags_n     = mags;
    timer_n    = timer;
    burst_n    = burst;
    shot_start = 1'b0;
    shot_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cond) begin
          if (bullets != '0) begin
            shot_start = 1'b1;
            bullets_n  = bullets - AMMO_ONE;
            // The mode is captured here by the choice of state; later changes are ignored.
            case (mode_t'(bus.firing_mode))
              MODE_BURST: begin
                state_n = ST_BURST;
                burst_n = BURST_LOAD;
              end
              MODE_AUTO: state_n = ST_AUTO;
              default:   state_n = ST_SINGLE;
            endcase
          end else begin
            state_n = empty_state;
            timer_n = RELOAD_LOAD;
          end
        end
      end
      ST_SINGLE, ST_BURST: begin
        if (bus.overheat_sensor) begin
          state_n    = ST_OVERHEAT;
          timer_n    = COOL_LOAD;
          shot_abort = 1'b1;
        end else if (state == ST_BURST && shot_done && bullets != '0 && burst != '0 && cond) begin
          shot_start = 1'b1;
          bullets_n  = bullets - AMMO_ONE;
          burst_n    = burst - BURST_ONE;
        end else if (shot_done || !shot_busy) begin
          // Last shot finished: refill if empty, otherwise wait for trigger release.
          if (bullets == '0) begin
            state_n = empty_state;
            timer_n = RELOAD_LOAD;
          end else if (!bus.fire_command) begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_AUTO: begin
        if (bus.overheat_sensor) begin
          state_n    = ST_OVERHEAT;
          timer_n    = COOL_LOAD;
          shot_abort = 1'b1;
        end else if (shot_done) begin
          if (bullets == '0) begin
            state_n = empty_state;
            timer_n = RELOAD_LOAD;
          end else if (!cond) begin
            state_n = ST_IDLE;
          end else begin
            shot_start = 1'b1;
            bullets_n  = bullets - AMMO_ONE;
          end
        end
      end
      ST_OVERHEAT: begin
        if (timer != '0) begin
          timer_n = timer - TIMER_ONE;
        end else if (!bus.overheat_sensor) begin
          if (bullets == '0) begin
            state_n = empty_state;
            timer_n = RELOAD_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_RELOAD: begin
        if (timer != '0) begin
          timer_n = timer - TIMER_ONE;
        end else begin
          state_n   = ST_IDLE;
          bullets_n = FULL_MAG;
          if (mags != '0) mags_n = mags - AMMO_ONE;
        end
      end
      ST_DOWNFALL: begin
        if (bus.rearm) begin
          state_n   = ST_IDLE;
          bullets_n = FULL_MAG;
          mags_n    = FULL_SPARES;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      state   <= ST_IDLE;
      bullets <= FULL_MAG;
      mags    <= FULL_SPARES;
      timer   <= '0;
      burst   <= '0;
      alert   <= (MAG_COUNT == 0);
    end else begin
      state   <= state_n;
      bullets <= bullets_n;
      mags    <= mags_n;
      timer   <= timer_n;
      burst   <= burst_n;
      alert   <= (mags == '0);
    end
  end

  assign bus.current_state     = state;
  assign bus.fire_trigger      = trigger;
  assign bus.criticality_alert = alert;
  assign bus.bullets_left      = bullets;
  assign bus.mags_left         = mags;

endmodule

// File: tb/tb_siganfu_turret_controller.sv
// Self-checking bench: expected trigger pulses are queued when stimulus is
// applied and compared by a pulse monitor; state/ammo checkpoints are inline.
module tb_siganfu_turret_controller;

  localparam logic [2:0] S_IDLE = 3'b000, S_SINGLE = 3'b001, S_AUTO = 3'b010,
                         S_RELOAD = 3'b011, S_OVERHEAT = 3'b100,
                         S_DOWNFALL = 3'b101, S_BURST = 3'b110;

  logic sysclk;
  logic reboot_n;

  siganfu_turret_controller_if #(.AMMO_W(8)) bus ();

  siganfu_turret_controller dut (
    .sysclk   (sysclk),
    .reboot_n (reboot_n),
    .bus      (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int width;
    int bullets;
    int mags;
  } pulse_t;

  pulse_t exp_q[$];

  task automatic push_pulses(input int n, input int first_bullets, input int mags, input int width);
    for (int i = 0; i < n; i++) begin
      pulse_t p;
      p.width   = width;
      p.bullets = first_bullets - i;
      p.mags    = mags;
      exp_q.push_back(p);
    end
  endtask

  // Pulse monitor: measures each trigger pulse and the ammo seen as it rose.
  int mon_w = 0;
  int mon_b = 0;
  int mon_m = 0;
  always @(negedge sysclk) begin
    if (bus.fire_trigger === 1'b1) begin
      if (mon_w == 0) begin
        mon_b = int'(bus.bullets_left);
        mon_m = int'(bus.mags_left);
      end
      mon_w++;
    end else if (mon_w > 0) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", 32'(1), 32'(0));
      end else begin
        pulse_t p;
        p = exp_q.pop_front();
        check("pulse_width",   32'(mon_w), 32'(p.width));
        check("pulse_bullets", 32'(mon_b), 32'(p.bullets));
        check("pulse_mags",    32'(mon_m), 32'(p.mags));
      end
      mon_w = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int i = 0;
    while (bus.current_state !== st && i < budget) begin
      @(negedge sysclk);
      i++;
    end
    check(tag, 32'(bus.current_state), 32'(st));
  endtask

  task automatic check_full_reset(input string tag);
    check({tag, "_state"},   32'(bus.current_state), 32'(S_IDLE));
    check({tag, "_trigger"}, 32'(bus.fire_trigger),  32'(0));
    check({tag, "_bullets"}, 32'(bus.bullets_left),  32'(25));
    check({tag, "_mags"},    32'(bus.mags_left),     32'(3));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reboot_n            = 1'b0;
    bus.target_locked   = 1'b0;
    bus.is_enemy        = 1'b0;
    bus.fire_command    = 1'b0;
    bus.firing_mode     = 2'b00;
    bus.overheat_sensor = 1'b0;
    bus.rearm           = 1'b0;
    tick(2);
    check_full_reset("reset");
    check("reset_alert", 32'(bus.criticality_alert), 32'(0));
    reboot_n = 1'b1;
    tick(1);

    // Single shot, held trigger: one pulse, no repeat.
    bus.firing_mode   = 2'b00;
    bus.is_enemy      = 1'b1;
    bus.target_locked = 1'b1;
    bus.fire_command  = 1'b1;
    push_pulses(1, 24, 3, 5);
    tick(1);
    check("single_latency", 32'(bus.fire_trigger), 32'(1));
    tick(39);
    check("single_hold_state", 32'(bus.current_state), 32'(S_SINGLE));
    check("single_bullets", 32'(bus.bullets_left), 32'(24));
    bus.fire_command = 1'b0;
    tick(1);
    check("single_release", 32'(bus.current_state), 32'(S_IDLE));

    // Mode 11 behaves as single.
    bus.firing_mode  = 2'b11;
    bus.fire_command = 1'b1;
    push_pulses(1, 23, 3, 5);
    tick(12);
    check("mode11_state", 32'(bus.current_state), 32'(S_SINGLE));
    bus.fire_command = 1'b0;
    tick(1);
    check("mode11_release", 32'(bus.current_state), 32'(S_IDLE));

    // Burst of three.
    bus.firing_mode  = 2'b01;
    bus.fire_command = 1'b1;
    push_pulses(3, 22, 3, 5);
    tick(35);
    check("burst_hold_state", 32'(bus.current_state), 32'(S_BURST));
    check("burst_bullets", 32'(bus.bullets_left), 32'(20));
    bus.fire_command = 1'b0;
    tick(1);
    check("burst_release", 32'(bus.current_state), 32'(S_IDLE));

    // Auto with a mid-stream mode change, then lock lost mid-pulse.
    bus.firing_mode  = 2'b10;
    bus.fire_command = 1'b1;
    push_pulses(18, 19, 3, 5);
    tick(30);
    bus.firing_mode = 2'b00;
    begin
      int i = 0;
      while (!(bus.bullets_left == 8'd2 && bus.fire_trigger === 1'b1) && i < 400) begin
        @(negedge sysclk);
        i++;
      end
      check("auto_reach_2", 32'(bus.bullets_left), 32'(2));
    end
    tick(1);
    bus.target_locked = 1'b0;
    tick(8);
    check("auto_gap_state", 32'(bus.current_state), 32'(S_AUTO));
    tick(1);
    check("auto_condloss_idle", 32'(bus.current_state), 32'(S_IDLE));

    // Burst with two rounds left stops early, then reloads for 50 cycles.
    bus.firing_mode   = 2'b01;
    bus.target_locked = 1'b1;
    push_pulses(2, 1, 3, 5);
    wait_state("burst_short_reload", S_RELOAD, 40);
    bus.fire_command = 1'b0;
    tick(49);
    check("reload_duration", 32'(bus.current_state), 32'(S_RELOAD));
    tick(1);
    check("reload_done_state", 32'(bus.current_state), 32'(S_IDLE));
    check("reload_bullets", 32'(bus.bullets_left), 32'(25));
    check("reload_mags", 32'(bus.mags_left), 32'(2));
    check("reload_alert", 32'(bus.criticality_alert), 32'(0));

    // Asynchronous reset in the middle of a pulse.
    bus.firing_mode  = 2'b10;
    bus.fire_command = 1'b1;
    push_pulses(1, 24, 2, 2);
    tick(2);
    #1 reboot_n = 1'b0;
    #1 check_full_reset("rst_pulse");
    bus.fire_command = 1'b0;
    #1 reboot_n = 1'b1;
    tick(1);

    // Auto through all magazines to downfall, then rearm.
    bus.fire_command = 1'b1;
    for (int m = 3; m >= 0; m--) push_pulses(25, 24, m, 5);
    wait_state("auto_downfall", S_DOWNFALL, 1400);
    check("downfall_trigger", 32'(bus.fire_trigger), 32'(0));
    check("downfall_bullets", 32'(bus.bullets_left), 32'(0));
    check("downfall_mags", 32'(bus.mags_left), 32'(0));
    check("downfall_alert", 32'(bus.criticality_alert), 32'(1));
    bus.fire_command = 1'b0;
    tick(3);
    check("downfall_stays", 32'(bus.current_state), 32'(S_DOWNFALL));
    bus.rearm = 1'b1;
    tick(1);
    bus.rearm = 1'b0;
    check_full_reset("rearm");
    tick(1);
    check("rearm_alert", 32'(bus.criticality_alert), 32'(0));

    // Overheat in the 2nd cycle of a pulse, sensor held ~150 cycles.
    bus.fire_command = 1'b1;
    push_pulses(1, 24, 3, 2);
    tick(2);
    bus.overheat_sensor = 1'b1;
    bus.fire_command    = 1'b0;
    tick(1);
    check("hot_state", 32'(bus.current_state), 32'(S_OVERHEAT));
    check("hot_trigger", 32'(bus.fire_trigger), 32'(0));
    check("hot_bullets", 32'(bus.bullets_left), 32'(24));
    tick(148);
    check("hot_long_hold", 32'(bus.current_state), 32'(S_OVERHEAT));
    bus.overheat_sensor = 1'b0;
    tick(1);
    check("hot_long_exit", 32'(bus.current_state), 32'(S_IDLE));

    // Short overheat: exit exactly after the 100-cycle cooldown.
    bus.fire_command = 1'b1;
    push_pulses(1, 23, 3, 1);
    tick(1);
    bus.overheat_sensor = 1'b1;
    bus.fire_command    = 1'b0;
    tick(1);
    check("cool_entry", 32'(bus.current_state), 32'(S_OVERHEAT));
    tick(9);
    bus.overheat_sensor = 1'b0;
    tick(90);
    check("cool_last_cycle", 32'(bus.current_state), 32'(S_OVERHEAT));
    tick(1);
    check("cool_exit", 32'(bus.current_state), 32'(S_IDLE));

    // Drain the magazine, then reset asynchronously mid-reload.
    bus.fire_command = 1'b1;
    push_pulses(23, 22, 3, 5);
    wait_state("drain_reload", S_RELOAD, 300);
    bus.fire_command = 1'b0;
    tick(20);
    #1 reboot_n = 1'b0;
    #1 check_full_reset("rst_reload");
    #1 reboot_n = 1'b1;
    tick(3);
    check("rst_reload_idle", 32'(bus.current_state), 32'(S_IDLE));

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
